// File: rtl/machine_csr_unit.sv
// Machine-mode CSR unit: architectural CSR decode, atomic write/set/clear, hardware
// counters with inhibit, trap/mret interrupt-enable stacking and trap-vector generation.
module machine_csr_unit #(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_HPM       = 4,
  parameter int RETIRE_WIDTH  = 2,
  parameter int VECTORED_EN   = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [11:0]                           csrAddress,
  input  logic [1:0]                            csrOp,
  input  logic [31:0]                           csrWriteData,
  output logic [31:0]                           csrReadData,
  output logic                                  csrIllegal,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0]     retireCount,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpmEvent,
  input  logic                                  irqSoftware,
  input  logic                                  irqTimer,
  input  logic                                  irqExternal,
  input  logic                                  trapTake,
  input  logic                                  trapInterrupt,
  input  logic [4:0]                            trapCause,
  input  logic [31:0]                           trapPC,
  input  logic [31:0]                           trapValue,
  input  logic                                  mretTake,
  output logic [31:0]                           trapVector,
  output logic [31:0]                           mepcOut,
  output logic                                  interruptPending
);

  localparam int HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1;
  // Slot 0 mcycle, slot 1 minstret, slots 2.. the hpm counters.
  localparam int NCNT = 2 + HPM_W;
  localparam bit HAS_HI = (COUNTER_WIDTH > 32);
  localparam logic [63:0] HPM_BITS = ((64'd1 << NUM_HPM) - 64'd1) << 3;
  localparam logic [31:0] INH_MASK = HPM_BITS[31:0] | 32'h0000_0005;

  function automatic logic [31:0] applyOp(input logic [1:0] op, input logic [31:0] old,
                                          input logic [31:0] operand);
    case (op)
      2'd2:    return old | operand;
      2'd3:    return old & ~operand;
      default: return operand;
    endcase
  endfunction

  logic                     mstatusMie;
  logic                     mstatusMpie;
  logic [2:0]               mieBits;
  logic [29:0]              mtvecBase;
  logic [1:0]               mtvecMode;
  logic [31:0]              mcountinhibit;
  logic [31:0]              mscratch;
  logic [31:0]              mepc;
  logic [31:0]              mcause;
  logic [31:0]              mtval;
  logic [COUNTER_WIDTH-1:0] counter [NCNT];
  logic [COUNTER_WIDTH-1:0] cntNext [NCNT];

  logic [31:0] mstatusValue;
  logic [31:0] mieValue;
  logic [31:0] mipValue;
  logic [31:0] readValue;
  logic        implemented;
  logic        readOnly;
  logic        cntHit;
  logic        cntHi;
  int          cntSel;
  logic [63:0] cntRead;
  logic        wen;
  logic [31:0] wval;
  logic [NCNT-1:0] cntEvent;
  logic [NCNT-1:0] cntInhibit;

  assign mstatusValue = {19'b0, 2'b11, 3'b0, mstatusMpie, 3'b0, mstatusMie, 3'b0};
  assign mieValue     = {20'b0, mieBits[2], 3'b0, mieBits[1], 3'b0, mieBits[0], 3'b0};
  assign mipValue     = {20'b0, irqExternal, 3'b0, irqTimer, 3'b0, irqSoftware, 3'b0};

  always_comb begin
    readValue   = '0;
    implemented = 1'b1;
    readOnly    = 1'b0;
    cntHit      = 1'b0;
    cntHi       = 1'b0;
    cntSel      = 0;
    cntRead     = '0;
    case (csrAddress)
      12'h300: readValue = mstatusValue;
      12'h301: readValue = 32'h4000_0100;
      12'h304: readValue = mieValue;
      12'h305: readValue = {mtvecBase, mtvecMode};
      12'h320: readValue = mcountinhibit;
      12'h340: readValue = mscratch;
      12'h341: readValue = mepc;
      12'h342: readValue = mcause;
      12'h343: readValue = mtval;
      12'h344: readValue = mipValue;
      12'hF11, 12'hF12, 12'hF13, 12'hF14: readOnly = 1'b1;
      default: begin
        implemented = 1'b0;
        // Counter window 0xB00-0xB1F, upper halves at +0x80.
        if (csrAddress[11:8] == 4'hB && csrAddress[6:5] == 2'b00 && (!csrAddress[7] || HAS_HI)) begin
          cntHi = csrAddress[7];
          if (csrAddress[4:0] == 5'd0) begin
            cntHit = 1'b1;
            cntSel = 0;
          end else if (csrAddress[4:0] == 5'd2) begin
            cntHit = 1'b1;
            cntSel = 1;
          end else if (csrAddress[4:0] >= 5'd3 && int'(csrAddress[4:0]) < 3 + NUM_HPM) begin
            cntHit = 1'b1;
            cntSel = int'(csrAddress[4:0]) - 1;
          end
          implemented = cntHit;
          for (int k = 0; k < NCNT; k++) begin
            if (cntHit && cntSel == k) cntRead = 64'(counter[k]);
          end
          readValue = cntHi ? cntRead[63:32] : cntRead[31:0];
        end
      end
    endcase
  end

  assign csrIllegal  = !implemented || (csrOp != 2'd0 && readOnly);
  assign csrReadData = csrIllegal ? 32'd0 : readValue;
  assign wen         = (csrOp != 2'd0) && !csrIllegal;
  assign wval        = applyOp(csrOp, readValue, csrWriteData);

  assign cntEvent   = {hpmEvent, 1'b0, 1'b1};
  assign cntInhibit = {(NUM_HPM == 0) ? {HPM_W{1'b1}} : mcountinhibit[3 +: HPM_W],
                       mcountinhibit[2], mcountinhibit[0]};

  // A CSR write to a counter half replaces it and takes precedence over the increment.
  always_comb begin
    logic [63:0] cur;
    for (int k = 0; k < NCNT; k++) begin
      cur = 64'(counter[k]);
      if (wen && cntHit && cntSel == k) begin
        if (cntHi) cur[63:32] = wval;
        else       cur[31:0]  = wval;
      end else if (!cntInhibit[k]) begin
        cur = cur + ((k == 1) ? 64'(retireCount) : 64'(cntEvent[k]));
      end
      cntNext[k] = cur[COUNTER_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NCNT; k++) counter[k] <= '0;
    end else begin
      for (int k = 0; k < NCNT; k++) counter[k] <= cntNext[k];
    end
  end

  // Trap beats mret beats CSR write on the trap-owned registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mstatusMie    <= 1'b0;
      mstatusMpie   <= 1'b0;
      mieBits       <= '0;
      mtvecBase     <= '0;
      mtvecMode     <= '0;
      mcountinhibit <= '0;
      mscratch      <= '0;
      mepc          <= '0;
      mcause        <= '0;
      mtval         <= '0;
    end else begin
      if (trapTake) begin
        mepc        <= trapPC & ~32'd3;
        mcause      <= {trapInterrupt, 26'b0, trapCause};
        mtval       <= trapValue;
        mstatusMpie <= mstatusMie;
        mstatusMie  <= 1'b0;
      end else if (mretTake) begin
        mstatusMie  <= mstatusMpie;
        mstatusMpie <= 1'b1;
      end else if (wen) begin
        case (csrAddress)
          12'h300: begin
            mstatusMie  <= wval[3];
            mstatusMpie <= wval[7];
          end
          12'h341: mepc   <= wval & ~32'd3;
          12'h342: mcause <= wval;
          12'h343: mtval  <= wval;
          default: ;
        endcase
      end
      if (wen) begin
        case (csrAddress)
          12'h304: mieBits <= {wval[11], wval[7], wval[3]};
          12'h305: begin
            mtvecBase <= wval[31:2];
            if (wval[1:0] == 2'b00)                          mtvecMode <= 2'b00;
            else if (wval[1:0] == 2'b01 && VECTORED_EN != 0) mtvecMode <= 2'b01;
          end
          12'h320: mcountinhibit <= wval & INH_MASK;
          12'h340: mscratch      <= wval;
          default: ;
        endcase
      end
    end
  end

  assign trapVector = {mtvecBase, 2'b00} +
                      ((mtvecMode == 2'b01 && mcause[31]) ? {25'b0, mcause[4:0], 2'b00} : 32'd0);
  assign mepcOut          = mepc;
  assign interruptPending = mstatusMie && |(mieValue & mipValue);

endmodule

// File: tb/tb_machine_csr_unit.sv
// Self-checking bench for machine_csr_unit: scoreboard of expected CSR reads plus
// direct checks of the combinational trap/interrupt outputs.
module tb_machine_csr_unit;

  logic        clock;
  logic        reset;
  logic [11:0] csrAddress;
  logic [1:0]  csrOp;
  logic [31:0] csrWriteData;
  logic [31:0] csrReadData;
  logic        csrIllegal;
  logic [1:0]  retireCount;
  logic [3:0]  hpmEvent;
  logic        irqSoftware, irqTimer, irqExternal;
  logic        trapTake, trapInterrupt;
  logic [4:0]  trapCause;
  logic [31:0] trapPC, trapValue;
  logic        mretTake;
  logic [31:0] trapVector, mepcOut;
  logic        interruptPending;

  machine_csr_unit #(
    .COUNTER_WIDTH(64), .NUM_HPM(4), .RETIRE_WIDTH(2), .VECTORED_EN(1)
  ) dut (
    .clock(clock), .reset(reset),
    .csrAddress(csrAddress), .csrOp(csrOp), .csrWriteData(csrWriteData),
    .csrReadData(csrReadData), .csrIllegal(csrIllegal),
    .retireCount(retireCount), .hpmEvent(hpmEvent),
    .irqSoftware(irqSoftware), .irqTimer(irqTimer), .irqExternal(irqExternal),
    .trapTake(trapTake), .trapInterrupt(trapInterrupt), .trapCause(trapCause),
    .trapPC(trapPC), .trapValue(trapValue), .mretTake(mretTake),
    .trapVector(trapVector), .mepcOut(mepcOut), .interruptPending(interruptPending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        it;
  logic [31:0] v;
  int          checks = 0;
  int          errors = 0;

  task automatic rd(input logic [11:0] addr, output logic [31:0] data);
    csrAddress = addr;
    #1;
    data = csrReadData;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
    csrAddress   = addr;
    csrOp        = op;
    csrWriteData = data;
    @(posedge clock);
    #1;
    csrOp = 2'd0;
  endtask

  task automatic do_trap(input logic intr, input logic [4:0] cause, input logic [31:0] pc,
                         input logic [31:0] val, input logic withMret);
    trapTake      = 1'b1;
    trapInterrupt = intr;
    trapCause     = cause;
    trapPC        = pc;
    trapValue     = val;
    mretTake      = withMret;
    @(posedge clock);
    #1;
    trapTake = 1'b0;
    mretTake = 1'b0;
    csrOp    = 2'd0;
  endtask

  task automatic test_reset;
    #12;
    sb.push_back('{"rst_mstatus", 12'h300, 32'h0000_1800});
    sb.push_back('{"rst_misa",    12'h301, 32'h4000_0100});
    sb.push_back('{"rst_mcycle",  12'hB00, 32'h0});
    sb.push_back('{"rst_mtvec",   12'h305, 32'h0});
    sb.push_back('{"rst_mie",     12'h304, 32'h0});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    checks++;
    if (trapVector !== 32'h0) begin errors++; $display("FAIL rst_trapvec got %h want 0", trapVector); end
    checks++;
    if (mepcOut !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h want 0", mepcOut); end
    checks++;
    if (interruptPending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b want 0", interruptPending); end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_csr_ops;
    wr(12'h340, 2'd1, 32'h1234_5678);
    wr(12'h340, 2'd2, 32'h0000_000F);
    wr(12'h340, 2'd3, 32'h0000_00F0);
    wr(12'h341, 2'd1, 32'h0000_1003);
    wr(12'h342, 2'd1, 32'h8000_000B);
    wr(12'h343, 2'd1, 32'h0000_CAFE);
    wr(12'h301, 2'd1, 32'h0);
    wr(12'h344, 2'd1, 32'hFFFF_FFFF);
    wr(12'h300, 2'd1, 32'hFFFF_FFFF);
    sb.push_back('{"mscratch_setclr", 12'h340, 32'h1234_560F});
    sb.push_back('{"mepc_align",      12'h341, 32'h0000_1000});
    sb.push_back('{"mcause_rw",       12'h342, 32'h8000_000B});
    sb.push_back('{"mtval_rw",        12'h343, 32'h0000_CAFE});
    sb.push_back('{"misa_const",      12'h301, 32'h4000_0100});
    sb.push_back('{"mip_ro",          12'h344, 32'h0});
    sb.push_back('{"mstatus_mask",    12'h300, 32'h0000_1888});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    checks++;
    if (mepcOut !== 32'h0000_1000) begin errors++; $display("FAIL mepc_out got %h want 00001000", mepcOut); end
    wr(12'h300, 2'd1, 32'h0);
    wr(12'h304, 2'd1, 32'hFFFF_FFFF);
    sb.push_back('{"mie_mask", 12'h304, 32'h0000_0888});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    wr(12'h304, 2'd3, 32'h0000_0808);
    sb.push_back('{"mie_clear", 12'h304, 32'h0000_0080});
    sb.push_back('{"mstatus_zero", 12'h300, 32'h0000_1800});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
  endtask

  task automatic test_mtvec;
    wr(12'h305, 2'd1, 32'h8000_0101);
    do_trap(1'b1, 5'd7, 32'h0000_1237, 32'h0000_DEAD, 1'b0);
    checks++;
    if (trapVector !== 32'h8000_011C) begin errors++; $display("FAIL vec_vectored got %h want 8000011c", trapVector); end
    checks++;
    if (mepcOut !== 32'h0000_1234) begin errors++; $display("FAIL trap_mepc got %h want 00001234", mepcOut); end
    sb.push_back('{"mtvec_vec",    12'h305, 32'h8000_0101});
    sb.push_back('{"trap_mcause",  12'h342, 32'h8000_0007});
    sb.push_back('{"trap_mtval",   12'h343, 32'h0000_DEAD});
    sb.push_back('{"trap_mstatus", 12'h300, 32'h0000_1800});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    wr(12'h305, 2'd1, 32'h8000_0202);
    sb.push_back('{"mtvec_mode2_keeps", 12'h305, 32'h8000_0201});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    checks++;
    if (trapVector !== 32'h8000_021C) begin errors++; $display("FAIL vec_newbase got %h want 8000021c", trapVector); end
    wr(12'h305, 2'd1, 32'h8000_0100);
    checks++;
    if (trapVector !== 32'h8000_0100) begin errors++; $display("FAIL vec_direct got %h want 80000100", trapVector); end
  endtask

  task automatic test_counter_carry;
    wr(12'hB00, 2'd1, 32'hFFFF_FFFE);
    wr(12'hB80, 2'd1, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    sb.push_back('{"mcycle_lo_carry", 12'hB00, 32'h0000_0001});
    sb.push_back('{"mcycle_hi_carry", 12'hB80, 32'h0000_0001});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
  endtask

  task automatic test_minstret_hpm;
    wr(12'hB02, 2'd1, 32'h0);
    wr(12'hB82, 2'd1, 32'h0);
    retireCount = 2'd2;
    repeat (5) @(posedge clock);
    #1;
    retireCount = 2'd0;
    sb.push_back('{"minstret_10",  12'hB02, 32'h0000_000A});
    sb.push_back('{"minstreth_0",  12'hB82, 32'h0});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    wr(12'h320, 2'd2, 32'h4);
    retireCount = 2'd2;
    repeat (3) @(posedge clock);
    #1;
    retireCount = 2'd0;
    hpmEvent = 4'b0010;
    repeat (4) @(posedge clock);
    #1;
    hpmEvent = 4'b0000;
    sb.push_back('{"minstret_frozen", 12'hB02, 32'h0000_000A});
    sb.push_back('{"inhibit_bit2",    12'h320, 32'h0000_0004});
    sb.push_back('{"hpm4_count",      12'hB04, 32'h0000_0004});
    sb.push_back('{"hpm3_idle",       12'hB03, 32'h0});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    wr(12'h320, 2'd2, 32'h10);
    hpmEvent = 4'b0010;
    repeat (3) @(posedge clock);
    #1;
    hpmEvent = 4'b0000;
    wr(12'h320, 2'd1, 32'hFFFF_FFFF);
    wr(12'hB04, 2'd1, 32'h55);
    sb.push_back('{"hpm4_frozen",  12'hB04, 32'h0000_0055});
    sb.push_back('{"inhibit_mask", 12'h320, 32'h0000_007D});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    wr(12'h320, 2'd1, 32'h0);
    hpmEvent = 4'b0001;
    wr(12'hB03, 2'd1, 32'h100);
    hpmEvent = 4'b0000;
    sb.push_back('{"hpm3_write_no_inc", 12'hB03, 32'h0000_0100});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
  endtask

  task automatic test_stacking;
    wr(12'h300, 2'd2, 32'h8);
    do_trap(1'b0, 5'd3, 32'h0000_0100, 32'h0, 1'b0);
    checks++;
    if (trapVector !== 32'h8000_0100) begin errors++; $display("FAIL vec_exception got %h want 80000100", trapVector); end
    sb.push_back('{"stack_trap", 12'h300, 32'h0000_1880});
    sb.push_back('{"exc_mcause", 12'h342, 32'h0000_0003});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    mretTake = 1'b1;
    @(posedge clock);
    #1;
    mretTake = 1'b0;
    sb.push_back('{"stack_mret", 12'h300, 32'h0000_1888});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    csrAddress = 12'h300; csrOp = 2'd1; csrWriteData = 32'h0;
    do_trap(1'b0, 5'd5, 32'h0000_0200, 32'h0, 1'b1);
    csrAddress = 12'h341; csrOp = 2'd1; csrWriteData = 32'h0000_FFF0;
    do_trap(1'b0, 5'd6, 32'h0000_0303, 32'h0, 1'b0);
    sb.push_back('{"trap_over_mret_prev", 12'h342, 32'h0000_0006});
    sb.push_back('{"trap_over_csr_mepc",  12'h341, 32'h0000_0300});
    sb.push_back('{"second_trap_mstatus", 12'h300, 32'h0000_1800});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    // Re-run the combined case and check mstatus straight after it.
    wr(12'h300, 2'd1, 32'h8);
    csrAddress = 12'h300; csrOp = 2'd1; csrWriteData = 32'h0;
    do_trap(1'b0, 5'd5, 32'h0000_0200, 32'h0, 1'b1);
    sb.push_back('{"trap_mret_together", 12'h300, 32'h0000_1880});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
  endtask

  task automatic test_pending;
    wr(12'h304, 2'd1, 32'h80);
    wr(12'h300, 2'd2, 32'h8);
    checks++;
    if (interruptPending !== 1'b0) begin errors++; $display("FAIL pend_noirq got %b want 0", interruptPending); end
    irqTimer = 1'b1;
    #1;
    checks++;
    if (interruptPending !== 1'b1) begin errors++; $display("FAIL pend_timer got %b want 1", interruptPending); end
    irqExternal = 1'b1;
    sb.push_back('{"mip_mirror", 12'h344, 32'h0000_0880});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    irqExternal = 1'b0;
    csrAddress = 12'h300; csrOp = 2'd3; csrWriteData = 32'h8;
    #1;
    checks++;
    if (interruptPending !== 1'b1) begin errors++; $display("FAIL pend_before_clear got %b want 1", interruptPending); end
    @(posedge clock);
    #1;
    csrOp = 2'd0;
    checks++;
    if (interruptPending !== 1'b0) begin errors++; $display("FAIL pend_after_clear got %b want 0", interruptPending); end
  endtask

  task automatic test_illegal;
    csrAddress = 12'h7C0; csrOp = 2'd1; csrWriteData = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (csrIllegal !== 1'b1) begin errors++; $display("FAIL illegal_7c0 got %b want 1", csrIllegal); end
    checks++;
    if (csrReadData !== 32'h0) begin errors++; $display("FAIL illegal_rdata got %h want 0", csrReadData); end
    @(posedge clock);
    #1;
    csrOp = 2'd0;
    csrAddress = 12'hF11; #1;
    checks++;
    if (csrIllegal !== 1'b0) begin errors++; $display("FAIL f11_read got %b want 0", csrIllegal); end
    csrOp = 2'd1; #1;
    checks++;
    if (csrIllegal !== 1'b1) begin errors++; $display("FAIL f11_write got %b want 1", csrIllegal); end
    csrOp = 2'd0;
    csrAddress = 12'hB01; #1;
    checks++;
    if (csrIllegal !== 1'b1) begin errors++; $display("FAIL b01 got %b want 1", csrIllegal); end
    csrAddress = 12'hB07; #1;
    checks++;
    if (csrIllegal !== 1'b1) begin errors++; $display("FAIL b07 got %b want 1", csrIllegal); end
    csrAddress = 12'hB86; #1;
    checks++;
    if (csrIllegal !== 1'b0) begin errors++; $display("FAIL b86 got %b want 0", csrIllegal); end
    csrAddress = 12'h344; csrOp = 2'd1; #1;
    checks++;
    if (csrIllegal !== 1'b0) begin errors++; $display("FAIL mip_write got %b want 0", csrIllegal); end
    csrOp = 2'd0;
    sb.push_back('{"illegal_no_change", 12'h340, 32'h1234_560F});
    sb.push_back('{"f14_zero",          12'hF14, 32'h0});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
  endtask

  task automatic test_async_reset;
    wr(12'h300, 2'd2, 32'h8);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (interruptPending !== 1'b0) begin errors++; $display("FAIL arst_pending got %b want 0", interruptPending); end
    checks++;
    if (trapVector !== 32'h0) begin errors++; $display("FAIL arst_trapvec got %h want 0", trapVector); end
    checks++;
    if (mepcOut !== 32'h0) begin errors++; $display("FAIL arst_mepc got %h want 0", mepcOut); end
    sb.push_back('{"arst_mstatus", 12'h300, 32'h0000_1800});
    sb.push_back('{"arst_mcycle",  12'hB00, 32'h0});
    sb.push_back('{"arst_mcycleh", 12'hB80, 32'h0});
    sb.push_back('{"arst_mscratch",12'h340, 32'h0});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    sb.push_back('{"first_increment", 12'hB00, 32'h0000_0001});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rd(it.addr, v);
      checks++;
      if (v !== it.exp) begin errors++; $display("FAIL %s got %h want %h", it.name, v, it.exp); end
    end
  endtask

  initial begin
    reset = 1'b0;
    csrAddress = 12'h300; csrOp = 2'd0; csrWriteData = 32'h0;
    retireCount = 2'd0; hpmEvent = 4'b0;
    irqSoftware = 1'b0; irqTimer = 1'b0; irqExternal = 1'b0;
    trapTake = 1'b0; trapInterrupt = 1'b0; trapCause = 5'd0;
    trapPC = 32'h0; trapValue = 32'h0; mretTake = 1'b0;
    test_reset();
    test_csr_ops();
    test_mtvec();
    test_counter_carry();
    test_minstret_hpm();
    test_stacking();
    test_pending();
    test_illegal();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
